// File: rtl/mem_responder.sv
// Word-organised on-chip RAM responder with a registered read pipeline, write-first forwarding,
// a post-reset zero-fill sequencer and misaligned/out-of-range access flagging.
module mem_responder #(
    parameter int ADDRWIDTH      = 32,
    parameter int BUSWIDTH       = 32,
    parameter int DEPTH          = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 cpu_rst,
    input  logic [ADDRWIDTH-1:0] rd_addr,
    input  logic [ADDRWIDTH-1:0] wr_addr,
    input  logic [BUSWIDTH-1:0]  wr_data,
    input  logic                 wren,
    output logic [BUSWIDTH-1:0]  rd_data,
    output logic                 rd_valid,
    output logic                 rd_err,
    output logic                 wr_err,
    output logic                 busy
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         clr_idx;
    logic [BUSWIDTH-1:0]   mem [DEPTH];

    logic                  ready;
    logic                  rd_bad, wr_bad, wr_ok, wr_drop;
    logic [IW-1:0]         rd_idx, wr_idx;
    logic                  cap_vld, cap_err;
    logic [BUSWIDTH-1:0]   cap_data;

    logic [BUSWIDTH-1:0]   data_p [READ_LATENCY];
    logic [READ_LATENCY-1:0] vld_p, err_p;

    // Upper address bits above the word index must be zero for an in-range access.
    function automatic logic addr_bad(input logic [ADDRWIDTH-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDRWIDTH-1:IW+2] != '0);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDRWIDTH-1:0] a);
        return a[IW+1:2];
    endfunction

    assign ready   = (state == READY);
    assign busy    = (state == CLEAR);
    assign rd_bad  = addr_bad(rd_addr);
    assign wr_bad  = addr_bad(wr_addr);
    assign rd_idx  = word_idx(rd_addr);
    assign wr_idx  = word_idx(wr_addr);
    assign wr_ok   = ready && wren && !wr_bad;
    assign wr_drop = ready && wren && wr_bad;

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_idx == IW'(DEPTH - 1))
            state_nxt = READY;
    end

    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_idx <= '0;
            wr_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_err  <= wr_drop;
            if (state == CLEAR)
                clr_idx <= clr_idx + 1'b1;
        end
    end

    // Storage is never reset so contents survive reset when the clear pass is disabled.
    always_ff @(posedge clk) begin
        if (!cpu_rst) begin
            if (state == CLEAR)
                mem[clr_idx] <= '0;
            else if (wr_ok)
                mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        cap_vld  = ready;
        cap_err  = ready && rd_bad;
        cap_data = '0;
        if (ready && !rd_bad)
            cap_data = (wr_ok && wr_idx == rd_idx) ? wr_data : mem[rd_idx];
    end

    // Stage 0 captures every edge; later stages shift so data is frozen at capture.
    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            for (int i = 0; i < READ_LATENCY; i++) data_p[i] <= '0;
            vld_p <= '0;
            err_p <= '0;
        end else begin
            data_p[0] <= cap_data;
            vld_p[0]  <= cap_vld;
            err_p[0]  <= cap_err;
            for (int i = 1; i < READ_LATENCY; i++) begin
                data_p[i] <= data_p[i-1];
                vld_p[i]  <= vld_p[i-1];
                err_p[i]  <= err_p[i-1];
            end
        end
    end

    assign rd_data  = data_p[READ_LATENCY-1];
    assign rd_valid = vld_p[READ_LATENCY-1];
    assign rd_err   = err_p[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a transaction-level memory model with a latency queue checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_responder;

    localparam int DEPTH = 16;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [31:0] rd_addr = '0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wren = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid, rd_err, wr_err, busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    mem_responder #(
        .ADDRWIDTH(32), .BUSWIDTH(32), .DEPTH(DEPTH),
        .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .cpu_rst(cpu_rst), .rd_addr(rd_addr), .wr_addr(wr_addr),
        .wr_data(wr_data), .wren(wren), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_err(rd_err), .wr_err(wr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word array, a busy countdown and a queue of results ordered by delivery time.
    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } slot_t;

    slot_t       exp_q[$];
    slot_t       m_s;
    logic [31:0] m_mem [DEPTH];
    logic        m_busy = 1'b1;
    logic        m_wr_err = 1'b0;
    int          clr_cnt = 0;
    logic        bad_r, bad_w;

    always @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            m_busy   = 1'b1;
            m_wr_err = 1'b0;
            clr_cnt  = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            exp_q.delete();
            for (int i = 0; i < LAT; i++) exp_q.push_back('0);
        end else begin
            bad_r = (rd_addr % 4 != 0) || (rd_addr >= DEPTH * 4);
            bad_w = (wr_addr % 4 != 0) || (wr_addr >= DEPTH * 4);
            if (m_busy)
                m_s = '0;
            else if (bad_r)
                m_s = {1'b1, 1'b1, 32'h0};
            else if (wren && !bad_w && (wr_addr / 4 == rd_addr / 4))
                m_s = {1'b1, 1'b0, wr_data};
            else
                m_s = {1'b1, 1'b0, m_mem[4'(rd_addr >> 2)]};
            exp_q.push_back(m_s);
            void'(exp_q.pop_front());
            m_wr_err = !m_busy && wren && bad_w;
            if (!m_busy && wren && !bad_w) m_mem[4'(wr_addr >> 2)] = wr_data;
            if (m_busy) begin
                clr_cnt++;
                if (clr_cnt == DEPTH) m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (cmp_en) begin
            if (exp_q.size() != LAT) begin
                checks++;
                errors++;
                $display("FAIL model_queue actual=%0d expected=%0d", exp_q.size(), LAT);
            end else begin
                check("cyc_busy",     32'(busy),     32'(m_busy));
                check("cyc_wr_err",   32'(wr_err),   32'(m_wr_err));
                check("cyc_rd_valid", 32'(rd_valid), 32'(exp_q[0].v));
                check("cyc_rd_err",   32'(rd_err),   32'(exp_q[0].e));
                check("cyc_rd_data",  rd_data,       exp_q[0].d);
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wren = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a,
                              input logic [31:0] d, input logic e);
        rd_addr = a; wren = 1'b0;
        repeat (LAT) @(negedge clk);
        check({name, "_valid"}, 32'(rd_valid), 32'd1);
        check({name, "_err"},   32'(rd_err),   32'(e));
        check({name, "_data"},  rd_data,       d);
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n++;
            @(negedge clk);
        end
        check(name, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_busy",  32'(busy),     32'd1);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data",  rd_data,       32'h0);

        // Clear pass after release, then top word reads as zero.
        cpu_rst = 1'b0;
        count_busy("clear_len");
        read_check("top_word", 32'h3C, 32'h0, 1'b0);

        // Write then read next cycle, two-cycle latency.
        wr(32'h10, 32'hDEADBEEF);
        read_check("rd_after_wr", 32'h10, 32'hDEADBEEF, 1'b0);

        // Same-edge write and read of one word.
        rd_addr = 32'h20;
        wr(32'h20, 32'h12345678);
        repeat (LAT - 1) @(negedge clk);
        check("wr_first", rd_data, 32'h12345678);

        // Misaligned write is dropped and flagged for one cycle.
        wr(32'h22, 32'hAAAA5555);
        check("wr_err_pulse", 32'(wr_err), 32'd1);
        @(negedge clk);
        check("wr_err_clear", 32'(wr_err), 32'd0);
        read_check("mem_kept", 32'h20, 32'h12345678, 1'b0);
        wr(32'h40, 32'h55555555);
        check("wr_err_range", 32'(wr_err), 32'd1);
        read_check("rd_range", 32'h40, 32'h0, 1'b1);
        read_check("rd_misal", 32'h21, 32'h0, 1'b1);

        // Back-to-back reads.
        wr(32'h0, 32'd1);
        wr(32'h4, 32'd2);
        wr(32'h8, 32'd3);
        rd_addr = 32'h0;
        @(negedge clk);
        rd_addr = 32'h4;
        @(negedge clk);
        rd_addr = 32'h8;
        check("b2b_0", rd_data, 32'd1);
        @(negedge clk);
        check("b2b_1", rd_data, 32'd2);
        @(negedge clk);
        check("b2b_2", rd_data, 32'd3);

        // Write hitting a word whose read is already in flight.
        rd_addr = 32'h4;
        @(negedge clk);
        rd_addr = 32'h3C;
        wr(32'h4, 32'd9);
        check("inflight_old", rd_data, 32'd2);
        read_check("inflight_new", 32'h4, 32'd9, 1'b0);

        // Reset during an in-flight read.
        rd_addr = 32'h4;
        @(negedge clk);
        cpu_rst = 1'b1;
        #1;
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data",  rd_data,       32'h0);
        check("rst_rd_busy",  32'(busy),     32'd1);
        @(negedge clk);
        cpu_rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reset in the middle of the clear pass restarts it in full.
        cpu_rst = 1'b1;
        #1;
        check("midclr_busy", 32'(busy), 32'd1);
        @(negedge clk);
        cpu_rst = 1'b0;
        count_busy("clear_restart");
        read_check("cleared_4",  32'h4,  32'h0, 1'b0);
        read_check("cleared_10", 32'h10, 32'h0, 1'b0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
